// File: rtl/collision_scheduler.sv
// collision_scheduler
// Shares one collision resolver across ENTITIES game objects. Each simulation
// tick freezes a snapshot of every entity and runs one resolver job per active
// slot in index order. The collected flags are published together with a
// single-cycle strobe.
module collision_scheduler #(
  parameter int ENTITIES = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sim_clk,
  input  logic [32*ENTITIES-1:0]  ent_state,
  input  logic [ENTITIES-1:0]     ent_active,
  output logic                    res_en,
  output logic [31:0]             res_state,
  input  logic                    res_valid,
  input  logic [3:0]              res_col,
  output logic [4*ENTITIES-1:0]   col_out,
  output logic                    col_strobe,
  output logic [ENTITIES-1:0]     fault,
  output logic                    overrun,
  output logic                    busy
);

  localparam int IDX_W = (ENTITIES > 1) ? $clog2(ENTITIES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SELECT  = 3'd1;
  localparam logic [2:0] LAUNCH  = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;
  localparam logic [2:0] COMMIT  = 3'd5;

  logic                   s1;
  logic                   s2;
  logic                   s3;
  logic [1:0]             sync_primed;
  logic                   frame_start;

  logic [2:0]             state;
  logic [ENTITIES-1:0]    pending;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       low_idx;
  logic [CNT_W-1:0]       cnt;
  logic [32*ENTITIES-1:0] snap;
  logic [4*ENTITIES-1:0]  col_shadow;
  logic [ENTITIES-1:0]    fault_shadow;

  // Synchronize the tick; s3 is forced high until s2 carries a real sample,
  // so a tick that is already high at reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b1;
      sync_primed <= 2'b00;
    end else begin
      s1          <= sim_clk;
      s2          <= s1;
      sync_primed <= {sync_primed[0], 1'b1};
      s3          <= sync_primed[1] ? s2 : 1'b1;
    end
  end

  assign frame_start = s2 & ~s3;
  assign busy        = (state != IDLE);

  // Lowest pending slot wins, giving index-order scheduling.
  always_comb begin
    low_idx = '0;
    for (int i = ENTITIES - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = IDX_W'(i);
    end
  end

  // A tick that lands mid-frame is dropped and only reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= frame_start && (state != IDLE);
  end

  // Frame sequencer: snapshot, per-slot launch/wait/release, then publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= '0;
      idx          <= '0;
      cnt          <= '0;
      snap         <= '0;
      col_shadow   <= '0;
      fault_shadow <= '0;
      res_en       <= 1'b0;
      res_state    <= '0;
      col_out      <= '0;
      fault        <= '0;
      col_strobe   <= 1'b0;
    end else begin
      col_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            snap         <= ent_state;
            pending      <= ent_active;
            col_shadow   <= '0;
            fault_shadow <= '0;
            state        <= (ent_active != '0) ? SELECT : COMMIT;
          end
        end
        SELECT: begin
          idx   <= low_idx;
          state <= LAUNCH;
        end
        LAUNCH: begin
          res_state <= snap[32*int'(idx) +: 32];
          res_en    <= 1'b1;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (res_valid) begin
            col_shadow[4*int'(idx) +: 4] <= res_col;
            res_en                       <= 1'b0;
            pending[idx]                 <= 1'b0;
            state                        <= RELEASE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            fault_shadow[idx] <= 1'b1;
            res_en            <= 1'b0;
            pending[idx]      <= 1'b0;
            state             <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!res_valid) state <= (pending != '0) ? SELECT : COMMIT;
        end
        COMMIT: begin
          col_out    <= col_shadow;
          fault      <= fault_shadow;
          col_strobe <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler
// Directed bench for collision_scheduler with a behavioural resolver model
// and a passive monitor; each scenario task checks its own expectations.
module tb_collision_scheduler;

  localparam int ENTITIES = 4;
  localparam int TIMEOUT  = 64;

  localparam logic [31:0] E0   = 32'h1234_5670;
  localparam logic [31:0] E1   = 32'h2468_ACE1;
  localparam logic [31:0] E2   = 32'h369C_F252;
  localparam logic [31:0] E3   = 32'h0F0F_0F03;
  localparam logic [31:0] E0_B = 32'hDEAD_BEE0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sim_clk = 1'b0;
  logic [127:0] ent_state;
  logic [3:0]   ent_active;
  logic         res_en;
  logic [31:0]  res_state;
  logic         res_valid = 1'b0;
  logic [3:0]   res_col = 4'h0;
  logic [15:0]  col_out;
  logic         col_strobe;
  logic [3:0]   fault;
  logic         overrun;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  // resolver model controls (written only by the scenario tasks)
  int         model_lat  = 10;
  int         model_hold = 0;
  int         mute_slot  = -1;
  logic [3:0] col_table [4];

  // resolver model records
  int          n_launch = 0;
  logic [31:0] launch_state [64];
  int          en_len [64];
  int          gap [64];
  int          valid_at_launch = 0;
  int          en_cycles = 0;
  int          hold_cnt = 0;
  int          low_samples = 0;
  logic        prev_en = 1'b0;

  // monitor records
  int          strobe_cnt = 0;
  int          overrun_cnt = 0;
  int          busy_cnt = 0;
  int          col_glitch = 0;
  int          state_glitch = 0;
  int          en_idle_cnt = 0;
  logic [15:0] prev_col = '0;
  logic [31:0] prev_state = '0;
  logic        mon_prev_en = 1'b0;

  collision_scheduler #(.ENTITIES(ENTITIES), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .sim_clk    (sim_clk),
    .ent_state  (ent_state),
    .ent_active (ent_active),
    .res_en     (res_en),
    .res_state  (res_state),
    .res_valid  (res_valid),
    .res_col    (res_col),
    .col_out    (col_out),
    .col_strobe (col_strobe),
    .fault      (fault),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Resolver model: answers model_lat cycles into a request (slot taken from
  // res_state[1:0]) and holds valid model_hold extra cycles after en drops.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      res_valid   = 1'b0;
      en_cycles   = 0;
      hold_cnt    = 0;
      low_samples = 0;
      prev_en     = 1'b0;
    end else begin
      if (res_en && !prev_en) begin
        if (res_valid) valid_at_launch++;
        if (n_launch < 64) begin
          launch_state[n_launch] = res_state;
          gap[n_launch]          = low_samples;
        end
        n_launch++;
        low_samples = 0;
        en_cycles   = 0;
      end
      if (!res_en && prev_en && n_launch > 0 && n_launch <= 64) en_len[n_launch-1] = en_cycles;
      if (!res_en) low_samples++;
      if (res_en) begin
        en_cycles++;
        if (!res_valid && en_cycles == model_lat && int'(res_state[1:0]) != mute_slot) begin
          res_valid = 1'b1;
          res_col   = col_table[res_state[1:0]];
          hold_cnt  = 0;
        end
      end else if (res_valid) begin
        if (hold_cnt == model_hold) res_valid = 1'b0;
        else hold_cnt++;
      end
      prev_en = res_en;
    end
  end

  // Passive monitor of the published outputs and request handshake.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      prev_col    = col_out;
      mon_prev_en = 1'b0;
    end else begin
      if (col_strobe) strobe_cnt++;
      if (overrun) overrun_cnt++;
      if (busy) busy_cnt++;
      if (col_out !== prev_col && !col_strobe) col_glitch++;
      if (res_en && !busy) en_idle_cnt++;
      if (res_en && mon_prev_en && res_state !== prev_state) state_glitch++;
      prev_col    = col_out;
      prev_state  = res_state;
      mon_prev_en = res_en;
    end
  end

  task automatic wait_strobe(input int budget, output bit got,
                             output logic [15:0] col, output logic [3:0] flt);
    got = 1'b0;
    col = '0;
    flt = '0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      #1;
      if (col_strobe) begin
        got = 1'b1;
        col = col_out;
        flt = fault;
      end
    end
  endtask

  task automatic test_reset();
    int b_busy, b_strobe;
    rst = 1'b1;
    sim_clk = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (res_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_res_en: got %b expected 0", res_en); end
    vectors++; if (res_state !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_res_state: got %h expected 0", res_state); end
    vectors++; if (col_out !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_col_out: got %h expected 0", col_out); end
    vectors++; if (col_strobe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_col_strobe: got %b expected 0", col_strobe); end
    vectors++; if (fault !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    b_busy = busy_cnt;
    b_strobe = strobe_cnt;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    vectors++; if (busy_cnt - b_busy != 0) begin miscompares++; $display("[TB] FAIL no_spurious_busy: got %0d busy cycles expected 0", busy_cnt - b_busy); end
    vectors++; if (strobe_cnt - b_strobe != 0) begin miscompares++; $display("[TB] FAIL no_spurious_strobe: got %0d expected 0", strobe_cnt - b_strobe); end
    sim_clk = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic();
    int b_l, b_s, b_o, b_v, b_g, b_sg, b_ei;
    bit got;
    logic [15:0] col;
    logic [3:0] flt;
    ent_active = 4'b0101;
    b_l = n_launch; b_s = strobe_cnt; b_o = overrun_cnt; b_v = valid_at_launch;
    b_g = col_glitch; b_sg = state_glitch; b_ei = en_idle_cnt;
    @(negedge clk);
    sim_clk = 1'b1;
    wait_strobe(200, got, col, flt);
    sim_clk = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_strobe_seen: got %b expected 1", got); end
    vectors++; if (col !== 16'h0802) begin miscompares++; $display("[TB] FAIL basic_col_out: got %h expected 0802", col); end
    vectors++; if (flt !== 4'b0000) begin miscompares++; $display("[TB] FAIL basic_fault: got %b expected 0000", flt); end
    vectors++; if (n_launch - b_l != 2) begin miscompares++; $display("[TB] FAIL basic_launches: got %0d expected 2", n_launch - b_l); end
    vectors++; if (launch_state[b_l] !== E0) begin miscompares++; $display("[TB] FAIL basic_state0: got %h expected %h", launch_state[b_l], E0); end
    vectors++; if (launch_state[b_l+1] !== E2) begin miscompares++; $display("[TB] FAIL basic_state2: got %h expected %h", launch_state[b_l+1], E2); end
    vectors++; if (en_len[b_l] != 10) begin miscompares++; $display("[TB] FAIL basic_en_len0: got %0d expected 10", en_len[b_l]); end
    vectors++; if (gap[b_l+1] != 3) begin miscompares++; $display("[TB] FAIL basic_release_gap: got %0d expected 3", gap[b_l+1]); end
    vectors++; if (strobe_cnt - b_s != 1) begin miscompares++; $display("[TB] FAIL basic_strobe_count: got %0d expected 1", strobe_cnt - b_s); end
    vectors++; if (overrun_cnt - b_o != 0) begin miscompares++; $display("[TB] FAIL basic_overrun: got %0d expected 0", overrun_cnt - b_o); end
    vectors++; if (valid_at_launch - b_v != 0) begin miscompares++; $display("[TB] FAIL basic_valid_at_launch: got %0d expected 0", valid_at_launch - b_v); end
    vectors++; if (col_glitch - b_g != 0) begin miscompares++; $display("[TB] FAIL basic_col_glitch: got %0d expected 0", col_glitch - b_g); end
    vectors++; if (state_glitch - b_sg != 0) begin miscompares++; $display("[TB] FAIL basic_state_stable: got %0d expected 0", state_glitch - b_sg); end
    vectors++; if (en_idle_cnt - b_ei != 0) begin miscompares++; $display("[TB] FAIL basic_en_outside_busy: got %0d expected 0", en_idle_cnt - b_ei); end
  endtask

  task automatic test_timeout();
    int b_l;
    bit got;
    logic [15:0] col;
    logic [3:0] flt;
    ent_active = 4'b0011;
    mute_slot = 1;
    b_l = n_launch;
    @(negedge clk);
    sim_clk = 1'b1;
    wait_strobe(300, got, col, flt);
    sim_clk = 1'b0;
    repeat (10) @(negedge clk);
    mute_slot = -1;
    vectors++; if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_strobe_seen: got %b expected 1", got); end
    vectors++; if (col !== 16'h0002) begin miscompares++; $display("[TB] FAIL timeout_col_out: got %h expected 0002", col); end
    vectors++; if (flt !== 4'b0010) begin miscompares++; $display("[TB] FAIL timeout_fault: got %b expected 0010", flt); end
    vectors++; if (n_launch - b_l != 2) begin miscompares++; $display("[TB] FAIL timeout_launches: got %0d expected 2", n_launch - b_l); end
    vectors++; if (en_len[b_l+1] != 64) begin miscompares++; $display("[TB] FAIL timeout_en_len: got %0d expected 64", en_len[b_l+1]); end
    vectors++; if (launch_state[b_l+1] !== E1) begin miscompares++; $display("[TB] FAIL timeout_state1: got %h expected %h", launch_state[b_l+1], E1); end
  endtask

  task automatic test_overrun();
    int b_l, b_s, b_o;
    bit got;
    logic [15:0] col;
    logic [3:0] flt;
    ent_active = 4'b0101;
    b_l = n_launch; b_s = strobe_cnt; b_o = overrun_cnt;
    @(negedge clk);
    sim_clk = 1'b1;
    repeat (12) @(negedge clk);
    sim_clk = 1'b0;
    repeat (3) @(negedge clk);
    sim_clk = 1'b1;
    wait_strobe(200, got, col, flt);
    sim_clk = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun_strobe_seen: got %b expected 1", got); end
    vectors++; if (col !== 16'h0802) begin miscompares++; $display("[TB] FAIL overrun_col_out: got %h expected 0802", col); end
    vectors++; if (flt !== 4'b0000) begin miscompares++; $display("[TB] FAIL overrun_fault: got %b expected 0000", flt); end
    vectors++; if (overrun_cnt - b_o != 1) begin miscompares++; $display("[TB] FAIL overrun_pulses: got %0d expected 1", overrun_cnt - b_o); end
    vectors++; if (strobe_cnt - b_s != 1) begin miscompares++; $display("[TB] FAIL overrun_strobe_count: got %0d expected 1", strobe_cnt - b_s); end
    vectors++; if (n_launch - b_l != 2) begin miscompares++; $display("[TB] FAIL overrun_launches: got %0d expected 2", n_launch - b_l); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL overrun_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_release_hold();
    int b_l, b_v;
    bit got;
    logic [15:0] col;
    logic [3:0] flt;
    ent_active = 4'b0101;
    model_hold = 5;
    b_l = n_launch; b_v = valid_at_launch;
    @(negedge clk);
    sim_clk = 1'b1;
    wait_strobe(200, got, col, flt);
    sim_clk = 1'b0;
    repeat (10) @(negedge clk);
    model_hold = 0;
    vectors++; if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_strobe_seen: got %b expected 1", got); end
    vectors++; if (col !== 16'h0802) begin miscompares++; $display("[TB] FAIL hold_col_out: got %h expected 0802", col); end
    vectors++; if (gap[b_l+1] != 8) begin miscompares++; $display("[TB] FAIL hold_release_gap: got %0d expected 8", gap[b_l+1]); end
    vectors++; if (valid_at_launch - b_v != 0) begin miscompares++; $display("[TB] FAIL hold_valid_at_launch: got %0d expected 0", valid_at_launch - b_v); end
  endtask

  task automatic test_snapshot();
    int b_l;
    bit got;
    logic [15:0] col;
    logic [3:0] flt;
    ent_active = 4'b0101;
    b_l = n_launch;
    @(negedge clk);
    sim_clk = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) begin
      @(posedge clk);
      #1;
    end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL snap_frame_started: got %b expected 1", busy); end
    @(negedge clk);
    ent_state[31:0] = E0_B;
    ent_active = 4'b1111;
    wait_strobe(200, got, col, flt);
    sim_clk = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (launch_state[b_l] !== E0) begin miscompares++; $display("[TB] FAIL snap_state0: got %h expected %h", launch_state[b_l], E0); end
    vectors++; if (n_launch - b_l != 2) begin miscompares++; $display("[TB] FAIL snap_launches: got %0d expected 2", n_launch - b_l); end
    vectors++; if (col !== 16'h0802) begin miscompares++; $display("[TB] FAIL snap_col_out: got %h expected 0802", col); end
    ent_state = {E3, E2, E1, E0};
    ent_active = 4'b0101;
  endtask

  task automatic test_reset_mid();
    int b_l, b_s;
    bit got;
    logic [15:0] col;
    logic [3:0] flt;
    ent_active = 4'b0101;
    @(negedge clk);
    sim_clk = 1'b1;
    for (int i = 0; i < 30 && !res_en; i++) begin
      @(posedge clk);
      #1;
    end
    vectors++; if (res_en !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_en_seen: got %b expected 1", res_en); end
    repeat (3) @(negedge clk);
    b_s = strobe_cnt;
    rst = 1'b1;
    #1;
    vectors++; if (res_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_res_en: got %b expected 0", res_en); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    vectors++; if (col_out !== 16'h0) begin miscompares++; $display("[TB] FAIL rstmid_col_out: got %h expected 0", col_out); end
    sim_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    vectors++; if (strobe_cnt - b_s != 0) begin miscompares++; $display("[TB] FAIL rstmid_no_strobe: got %0d expected 0", strobe_cnt - b_s); end
    b_l = n_launch;
    sim_clk = 1'b1;
    wait_strobe(200, got, col, flt);
    sim_clk = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_clean_strobe: got %b expected 1", got); end
    vectors++; if (col !== 16'h0802) begin miscompares++; $display("[TB] FAIL rstmid_clean_col: got %h expected 0802", col); end
    vectors++; if (n_launch - b_l != 2) begin miscompares++; $display("[TB] FAIL rstmid_clean_launches: got %0d expected 2", n_launch - b_l); end
  endtask

  task automatic test_no_active();
    int b_l, b_s;
    bit got;
    logic [15:0] col;
    logic [3:0] flt;
    ent_active = 4'b0000;
    b_l = n_launch; b_s = strobe_cnt;
    @(negedge clk);
    sim_clk = 1'b1;
    wait_strobe(50, got, col, flt);
    sim_clk = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("[TB] FAIL none_strobe_seen: got %b expected 1", got); end
    vectors++; if (col !== 16'h0000) begin miscompares++; $display("[TB] FAIL none_col_out: got %h expected 0000", col); end
    vectors++; if (flt !== 4'b0000) begin miscompares++; $display("[TB] FAIL none_fault: got %b expected 0000", flt); end
    vectors++; if (n_launch - b_l != 0) begin miscompares++; $display("[TB] FAIL none_launches: got %0d expected 0", n_launch - b_l); end
    vectors++; if (strobe_cnt - b_s != 1) begin miscompares++; $display("[TB] FAIL none_strobe_count: got %0d expected 1", strobe_cnt - b_s); end
  endtask

  initial begin
    ent_state  = {E3, E2, E1, E0};
    ent_active = 4'b0000;
    col_table[0] = 4'b0010;
    col_table[1] = 4'b0100;
    col_table[2] = 4'b1000;
    col_table[3] = 4'b0001;
    test_reset();
    test_basic();
    test_timeout();
    test_overrun();
    test_release_hold();
    test_snapshot();
    test_reset_mid();
    test_no_active();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Frame-level scheduler that time-shares one collision resolver among `ENTITIES` game objects (player slot 0, slimes 1..N-1). Each simulation tick it snapshots all entity states and launches one resolver job per active slot, in index order. It collects the 4-bit collision flags per slot and publishes them atomically with a one-cycle strobe. It sits between the physics/entity registers and the resolver, which owns the tile-map lookup port.

## Interface
- `ENTITIES`, 4: number of entity slots (2..8).
- `TIMEOUT`, 64: maximum cycles to wait for `res_valid` per job (≥16).
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `sim_clk` input 1: slow simulation tick, asynchronous to `clk`.
- `ent_state` input 32*ENTITIES: packed states; slot i at [32i+31:32i]. Format per slot: xPos[31:22], yPos[21:12], xSpeed[11:7], ySpeed[6:2], xDir[1], yDir[0].
- `ent_active` input ENTITIES: slot i is scheduled only if bit i is 1.
- `res_en` output 1: level request to resolver.
- `res_state` output 32: state of the slot being resolved.
- `res_valid` input 1: resolver result ready.
- `res_col` input 4: {top, right, bottom, left} flags.
- `col_out` output 4*ENTITIES: published flags; slot i at [4i+3:4i].
- `col_strobe` output 1: one-cycle pulse when `col_out`/`fault` update.
- `fault` output ENTITIES: slot timed out in the last published frame.
- `overrun` output 1: one-cycle pulse when a tick arrives while not IDLE.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- Tick detect: `sim_clk` passes through a 2-flop synchronizer (`s1`, `s2`, both reset to 0). An edge register `s3` is reset to 1. `frame_start` = `s2 & ~s3`. No spurious frame is generated at reset release.
- States: IDLE, SELECT, LAUNCH, WAIT, RELEASE, COMMIT.
- IDLE: on `frame_start`, copy `ent_state` into a snapshot, set `pending` to `ent_active`, and clear `col_shadow` and `fault_shadow`. Go to SELECT, or to COMMIT if `pending` is 0.
- SELECT: `idx` becomes the lowest set bit of `pending`. Go to LAUNCH.
- LAUNCH: drive `res_state` from snapshot[idx], set `res_en` to 1, clear the wait counter. Go to WAIT.
- WAIT: if `res_valid` is 1, write `res_col` to `col_shadow[idx]`, set `res_en` to 0, clear `pending[idx]`, and go to RELEASE. Otherwise increment the counter. When the counter reaches TIMEOUT-1, set `fault_shadow[idx]`, leave `col_shadow[idx]` at 0, set `res_en` to 0, clear `pending[idx]`, and go to RELEASE.
- RELEASE: hold until `res_valid` is 0, so the resolver has returned to idle. Then go to SELECT if `pending` ≠ 0, else COMMIT.
- COMMIT: copy `col_shadow` to `col_out` and `fault_shadow` to `fault`, pulse `col_strobe`, go to IDLE. Inactive slots publish 4'b0000.
- `res_state` is held stable from LAUNCH until the next LAUNCH.
- `res_en` is never high outside WAIT.
- `frame_start` outside IDLE: pulse `overrun`; the tick is dropped and the current frame continues unaffected.
- `ent_state`/`ent_active` changes mid-frame have no effect (snapshot rule).

## Timing
- Reset values: `res_en` 0, `res_state` 0, `col_out` 0, `col_strobe` 0, `fault` 0, `overrun` 0, `busy` 0, state IDLE, `pending` 0.
- Reset mid-frame: everything returns to reset values immediately; `res_en` drops asynchronously; no strobe.
- `sim_clk` rise to `frame_start`: 2–3 `clk` cycles. State leaves IDLE on the following edge.
- Per-slot cost: SELECT 1 + LAUNCH 1 + WAIT (resolver latency L, counted from the first WAIT cycle) + RELEASE ≥1 cycles.
- Frame latency for k active slots with latency L and immediate valid release: 1 (IDLE exit) + k·(L+3) + 1 (COMMIT). `col_strobe` is high in the cycle after COMMIT.
- `ent_active` = 0: `col_strobe` fires 2 cycles after `frame_start` with all zeros.
- `col_out` changes only in the same cycle `col_strobe` rises.

## Test plan
- ENTITIES=4, active=4'b0101, model resolver returns valid after 10 cycles with col=4'b0010 for slot 0 and 4'b1000 for slot 2 -> exactly two `res_en` pulses, slot 0 then slot 2, with matching `res_state`; `col_out`=16'h0802 (slot 0=0x2, slot 2=0x8, slots 1 and 3=0); one `col_strobe`; `fault`=0.
- Model never asserts valid for slot 1, active=4'b0011 -> `res_en` drops after 64 WAIT cycles; slot 1 publishes 0 and `fault`=4'b0010; slot 0 result is still published.
- Second `sim_clk` rise during the frame -> one `overrun` pulse; single `col_strobe`; results equal the uninterrupted run.
- Resolver holds valid 5 cycles after en drops -> next LAUNCH is not issued until valid is 0; `res_en` is never high while valid is high at LAUNCH.
- `ent_state` for slot 0 changed mid-frame -> `res_state` carries the snapshot value. Assert `rst` during WAIT -> `res_en`=0 in the same cycle, no strobe, and the next tick runs a clean frame.
- active=0 -> `col_strobe` fires with `col_out`=0 and `res_en` is never asserted. With `sim_clk`=1 at reset release -> no frame starts.
